noun_loader: RTL and testbench
==============================

# noun_loader

Postorder (RPN) token-stream-to-memory noun builder: the writer counterpart of `mem_traversal`. It accepts a stream of atom and cons tokens and allocates one memory cell per cons through the memory-unit request protocol. It reports the root cell address so `mem_traversal` or the NEM can walk the result. It is a third requester on `memory_mux` and drives its own `mux_controller` select.

## Interface
- `STACK_DEPTH`, default 16: operand stack entries.
- `F` (localparam) = (`` `memory_data_width `` − 4)/2: field width. Requires F ≥ `` `memory_addr_width ``.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `start`  in  1  arms the loader from IDLE, DONE or ERROR.
- `tok_valid`  in  1  token present.
- `tok_ready`  out  1  token accepted on a cycle where `tok_valid & tok_ready`.
- `tok_is_cons`  in  1  1 = CONS token, 0 = ATOM token.
- `tok_atom`  in  F  atom value; ignored for CONS.
- `tok_last`  in  1  final token of the noun.
- `mem_ready`  in  1  memory unit idle/complete.
- `mem_execute`  out  1  one-cycle request strobe.
- `mem_func`  out  2  2'b11 = alloc-write; no other code is ever issued.
- `address`  out  `` `memory_addr_width ``  driven to 0; alloc ignores it.
- `write_data`  out  `` `memory_data_width ``  cell word.
- `free_addr`  in  `` `memory_addr_width ``  address assigned by the alloc.
- `mux_controller`  out  1  1 = memory bus granted to loader.
- `root_addr`  out  `` `memory_addr_width ``  root cell address; valid while `finished & ~error`.
- `finished`  out  1  high in DONE or ERROR.
- `error`  out  1  high in ERROR.
- `error_code`  out  2  1 = underflow, 2 = overflow, 3 = bad final stack.

## Operation
- Cell word layout: [2F+3:2F+2] = 2'b00; [2F+1] = hed is atom; [2F] = tel is atom; [2F−1:F] = hed; [F−1:0] = tel. Pointers are zero-extended to F bits.
- Stack entry: {is_atom, F-bit value}. Depth counter runs 0..STACK_DEPTH.
- **IDLE**
  - Outputs are at their reset values.
  - `start` → ACCEPT. Depth is cleared and `mux_controller` goes to 1.
- **ACCEPT**
  - `tok_ready` = 1.
  - ATOM token: push {1, tok_atom}. If depth = STACK_DEPTH → ERROR, code 2, and no push occurs.
  - CONS token: if depth < 2 → ERROR, code 1. Otherwise pop tel (top), then hed, latch the word → ALLOC_REQ.
  - On an accepted ATOM with `tok_last`: run the final check next cycle.
- **ALLOC_REQ**
  - `tok_ready` = 0.
  - Wait for `mem_ready` = 1. Then assert `mem_execute` for exactly one cycle with `write_data` stable → ALLOC_WAIT.
- **ALLOC_WAIT**
  - Wait for `mem_ready` to go low, then high again (internal `seen_busy` flag).
  - On the high cycle: sample `free_addr` and push {0, free_addr}. Return to ACCEPT, or run the final check if this CONS carried `tok_last`.
- **Final check**
  - Depth = 1 and top is_atom = 0 → DONE, `root_addr` = top value.
  - Otherwise → ERROR, code 3.
- **DONE / ERROR**
  - Sticky. `mux_controller` = 0 and `tok_ready` = 0.
  - `start` re-arms the loader (→ ACCEPT, clears error).
- Tokens with `tok_valid` low are ignored. `tok_last` on a token that errors is irrelevant; the error wins.
- Cells already written are never freed or rewritten by the loader.

## Timing
- Reset values: `tok_ready`, `mem_execute`, `mux_controller`, `finished`, `error` = 0; `error_code`, `root_addr`, `address`, `write_data`, `mem_func` = 0; state = IDLE; depth = 0.
- An ATOM token costs 1 cycle. The next token can be accepted in the following cycle.
- A CONS token costs 1 accept cycle + ≥1 ALLOC_REQ cycle + the memory latency. `tok_ready` is low throughout.
- The final check costs 1 cycle after the last push. `finished` rises on the cycle after the check.
- `rst` mid-alloc: all outputs return to reset values on the next edge. The memory unit shares `rst`, so no request is left outstanding.
- `start` while in ACCEPT or during an alloc is ignored.

## Configuration
- `NOUN_LOADER_CELL_COUNT_EN` defined:
  - Adds output `cell_count` [`` `memory_addr_width ``−1:0].
  - Cleared on `start`/`rst`. Incremented on each completed alloc. Saturates at all-ones.
- `NOUN_LOADER_CELL_COUNT_EN` undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
(`` `memory_data_width `` = 64, F = 30; the bench memory allocates addresses 1, 2, 3…)
- ATOM 5, ATOM 7, CONS(last) → exactly one `mem_execute`, `write_data` = {2'b00, 1, 1, 30'd5, 30'd7}, `root_addr` = 1, `finished` = 1, `error` = 0.
- ATOM 1, ATOM 2, CONS, ATOM 3, CONS(last) → second word = {2'b00, 0, 1, 30'd1, 30'd3}, `root_addr` = 2; with the macro, `cell_count` = 2.
- CONS as the first token → `error` = 1, `error_code` = 1, `mem_execute` never asserted, `tok_ready` = 0 afterwards.
- 17 consecutive ATOMs (STACK_DEPTH = 16) → 17th token: `error_code` = 2, no further `tok_ready`.
- ATOM 4 (last) → `error_code` = 3; ATOM 1, ATOM 2 (last) → `error_code` = 3.
- CONS with `mem_ready` held low 10 cycles after the request → single `mem_execute`, `tok_ready` stays 0; `rst` during the wait → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/noun_loader.sv
// Postorder token-stream noun builder: pushes atoms, allocates one memory cell per CONS, reports the root.
// Optional NOUN_LOADER_CELL_COUNT_EN adds a saturating cell_count output.
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 64
`endif
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif

module noun_loader #(
    parameter int STACK_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            tok_valid,
    output logic                            tok_ready,
    input  logic                            tok_is_cons,
    input  logic [(`MEMORY_DATA_WIDTH-4)/2-1:0] tok_atom,
    input  logic                            tok_last,
    input  logic                            mem_ready,
    output logic                            mem_execute,
    output logic [1:0]                      mem_func,
    output logic [`MEMORY_ADDR_WIDTH-1:0]   address,
    output logic [`MEMORY_DATA_WIDTH-1:0]   write_data,
    input  logic [`MEMORY_ADDR_WIDTH-1:0]   free_addr,
    output logic                            mux_controller,
    output logic [`MEMORY_ADDR_WIDTH-1:0]   root_addr,
    output logic                            finished,
    output logic                            error,
`ifdef NOUN_LOADER_CELL_COUNT_EN
    output logic [`MEMORY_ADDR_WIDTH-1:0]   cell_count,
`endif
    output logic [1:0]                      error_code
);

    localparam int AW  = `MEMORY_ADDR_WIDTH;
    localparam int DW  = `MEMORY_DATA_WIDTH;
    localparam int F   = (DW - 4) / 2;
    localparam int SW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int DPW = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_ALLOC_REQ,
        S_ALLOC_WAIT,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [DPW-1:0]  depth_q, depth_d;
    logic [DW-1:0]   word_q, word_d;
    logic            last_q, last_d;
    logic            seen_busy_q, seen_busy_d;
    logic [AW-1:0]   root_q, root_d;
    logic [1:0]      code_q, code_d;
`ifdef NOUN_LOADER_CELL_COUNT_EN
    logic [AW-1:0]   cnt_q, cnt_d;
`endif

    // Stack entry: {is_atom, value}; top lives at index depth-1.
    logic [F:0]      stack_q [STACK_DEPTH];
    logic            push_en;
    logic [F:0]      push_val;
    logic [SW-1:0]   push_idx, top_idx, next_idx;
    logic [F:0]      top_e, next_e;

    assign push_idx = SW'(depth_q);
    assign top_idx  = SW'(depth_q - DPW'(1));
    assign next_idx = SW'(depth_q - DPW'(2));
    assign top_e    = stack_q[top_idx];
    assign next_e   = stack_q[next_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            depth_q     <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            seen_busy_q <= 1'b0;
            root_q      <= '0;
            code_q      <= '0;
`ifdef NOUN_LOADER_CELL_COUNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            word_q      <= word_d;
            last_q      <= last_d;
            seen_busy_q <= seen_busy_d;
            root_q      <= root_d;
            code_q      <= code_d;
`ifdef NOUN_LOADER_CELL_COUNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= push_val;
        end
    end

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        word_d      = word_q;
        last_d      = last_q;
        seen_busy_d = seen_busy_q;
        root_d      = root_q;
        code_d      = code_q;
        push_en     = 1'b0;
        push_val    = '0;
`ifdef NOUN_LOADER_CELL_COUNT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_ACCEPT;
                    depth_d = '0;
                    code_d  = '0;
                    root_d  = '0;
`ifdef NOUN_LOADER_CELL_COUNT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_ACCEPT: begin
                if (tok_valid) begin
                    if (!tok_is_cons) begin
                        if (depth_q == DPW'(STACK_DEPTH)) begin
                            state_d = S_ERROR;
                            code_d  = 2'd2;
                        end else begin
                            push_en  = 1'b1;
                            push_val = {1'b1, tok_atom};
                            depth_d  = depth_q + DPW'(1);
                            if (tok_last) begin
                                state_d = S_CHECK;
                            end
                        end
                    end else if (depth_q < DPW'(2)) begin
                        state_d = S_ERROR;
                        code_d  = 2'd1;
                    end else begin
                        // next_e is hed, top_e is tel.
                        word_d  = DW'({2'b00, next_e[F], top_e[F], next_e[F-1:0], top_e[F-1:0]});
                        depth_d = depth_q - DPW'(2);
                        last_d  = tok_last;
                        state_d = S_ALLOC_REQ;
                    end
                end
            end
            S_ALLOC_REQ: begin
                if (mem_ready) begin
                    seen_busy_d = 1'b0;
                    state_d     = S_ALLOC_WAIT;
                end
            end
            S_ALLOC_WAIT: begin
                if (!mem_ready) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    push_en  = 1'b1;
                    push_val = {1'b0, F'(free_addr)};
                    depth_d  = depth_q + DPW'(1);
                    state_d  = last_q ? S_CHECK : S_ACCEPT;
`ifdef NOUN_LOADER_CELL_COUNT_EN
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + AW'(1);
                    end
`endif
                end
            end
            S_CHECK: begin
                if (depth_q == DPW'(1) && !top_e[F]) begin
                    state_d = S_DONE;
                    root_d  = AW'(top_e[F-1:0]);
                end else begin
                    state_d = S_ERROR;
                    code_d  = 2'd3;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tok_ready      = (state_q == S_ACCEPT);
    assign mem_execute    = (state_q == S_ALLOC_REQ) && mem_ready;
    assign mux_controller = (state_q == S_ACCEPT) || (state_q == S_ALLOC_REQ) ||
                            (state_q == S_ALLOC_WAIT) || (state_q == S_CHECK);
    assign mem_func       = mux_controller ? 2'b11 : 2'b00;
    assign address        = '0;
    assign write_data     = word_q;
    assign root_addr      = root_q;
    assign finished       = (state_q == S_DONE) || (state_q == S_ERROR);
    assign error          = (state_q == S_ERROR);
    assign error_code     = code_q;
`ifdef NOUN_LOADER_CELL_COUNT_EN
    assign cell_count     = cnt_q;
`endif

endmodule

// File: tb/tb_noun_loader.sv
// Directed bench for noun_loader: vector table of token sequences plus hand-written alloc/reset corner cases.
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 64
`endif
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif

module tb_noun_loader;

    localparam int AW = `MEMORY_ADDR_WIDTH;
    localparam int DW = `MEMORY_DATA_WIDTH;
    localparam int F  = (DW - 4) / 2;
    localparam int CONS = -1;

    logic          clk, rst, start;
    logic          tok_valid, tok_ready, tok_is_cons, tok_last;
    logic [F-1:0]  tok_atom;
    logic          mem_ready, mem_execute;
    logic [1:0]    mem_func;
    logic [AW-1:0] address, free_addr, root_addr;
    logic [DW-1:0] write_data;
    logic          mux_controller, finished, error;
    logic [1:0]    error_code;
`ifdef NOUN_LOADER_CELL_COUNT_EN
    logic [AW-1:0] cell_count;
`endif

    noun_loader #(.STACK_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_cons(tok_is_cons),
        .tok_atom(tok_atom), .tok_last(tok_last),
        .mem_ready(mem_ready), .mem_execute(mem_execute), .mem_func(mem_func),
        .address(address), .write_data(write_data), .free_addr(free_addr),
        .mux_controller(mux_controller), .root_addr(root_addr),
        .finished(finished), .error(error),
`ifdef NOUN_LOADER_CELL_COUNT_EN
        .cell_count(cell_count),
`endif
        .error_code(error_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: allocates 1, 2, 3... after mem_lat busy cycles.
    int            mem_lat;
    int            busy_cnt;
    int            exec_count;
    logic [AW-1:0] next_addr;
    logic [DW-1:0] wr_q [$];

    always @(posedge clk) begin
        if (rst) begin
            mem_ready  <= 1'b1;
            busy_cnt   <= 0;
            next_addr  <= AW'(1);
            free_addr  <= '0;
            exec_count <= 0;
            wr_q.delete();
        end else if (mem_execute) begin
            busy_cnt   <= mem_lat;
            mem_ready  <= 1'b0;
            exec_count <= exec_count + 1;
            wr_q.push_back(write_data);
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt  <= 0;
            mem_ready <= 1'b1;
            free_addr <= next_addr;
            next_addr <= next_addr + AW'(1);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All tasks are entered and left on a negative edge.
    task automatic reset_dut();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_tok(input int tok, input logic last);
        int c;
        c           = 0;
        tok_valid   = 1'b1;
        tok_is_cons = (tok == CONS);
        tok_atom    = (tok == CONS) ? '0 : F'(tok);
        tok_last    = last;
        while (!tok_ready && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) check("tok_accept_timeout", 64'(tok_ready), 64'd1);
        @(negedge clk);
        tok_valid = 1'b0;
        tok_last  = 1'b0;
    endtask

    task automatic wait_finished(input string name);
        int c;
        c = 0;
        while (!finished && c < 200) begin
            @(negedge clk);
            c++;
        end
        check({name, "_finished"}, 64'(finished), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tok_ready"}, 64'(tok_ready), 64'd0);
        check({tag, "_mem_execute"}, 64'(mem_execute), 64'd0);
        check({tag, "_mux_controller"}, 64'(mux_controller), 64'd0);
        check({tag, "_finished"}, 64'(finished), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_error_code"}, 64'(error_code), 64'd0);
        check({tag, "_root_addr"}, 64'(root_addr), 64'd0);
        check({tag, "_address"}, 64'(address), 64'd0);
        check({tag, "_write_data"}, 64'(write_data), 64'd0);
        check({tag, "_mem_func"}, 64'(mem_func), 64'd0);
    endtask

    typedef struct {
        int            n;
        int            tok [6];
        logic          exp_err;
        logic [1:0]    exp_code;
        logic [AW-1:0] exp_root;
        int            exp_execs;
        logic [DW-1:0] exp_word;
    } vec_t;

    function automatic vec_t mk(input int n, input int t0, input int t1, input int t2,
                                input int t3, input int t4, input logic e, input logic [1:0] c,
                                input logic [AW-1:0] r, input int x, input logic [DW-1:0] w);
        vec_t v;
        v.n = n;
        v.tok[0] = t0; v.tok[1] = t1; v.tok[2] = t2;
        v.tok[3] = t3; v.tok[4] = t4; v.tok[5] = 0;
        v.exp_err = e; v.exp_code = c; v.exp_root = r;
        v.exp_execs = x; v.exp_word = w;
        return v;
    endfunction

    vec_t vecs [7];

    initial begin : main
        logic seen_ready;
        string nm;
        rst = 1'b1; start = 1'b0; tok_valid = 1'b0; tok_is_cons = 1'b0;
        tok_atom = '0; tok_last = 1'b0; mem_lat = 1;

        // Last word written in each sequence: {2'b00, hed_atom, tel_atom, hed, tel}.
        vecs[0] = mk(3, 5, 7, CONS, 0, 0, 1'b0, 2'd0, 16'd1, 1, {2'b00, 1'b1, 1'b1, 30'd5, 30'd7});
        vecs[1] = mk(5, 1, 2, CONS, 3, CONS, 1'b0, 2'd0, 16'd2, 2, {2'b00, 1'b0, 1'b1, 30'd1, 30'd3});
        vecs[2] = mk(1, CONS, 0, 0, 0, 0, 1'b1, 2'd1, 16'd0, 0, '0);
        vecs[3] = mk(1, 4, 0, 0, 0, 0, 1'b1, 2'd3, 16'd0, 0, '0);
        vecs[4] = mk(2, 1, 2, 0, 0, 0, 1'b1, 2'd3, 16'd0, 0, '0);
        vecs[5] = mk(4, 1, 2, CONS, CONS, 0, 1'b1, 2'd1, 16'd0, 1, {2'b00, 1'b1, 1'b1, 30'd1, 30'd2});
        vecs[6] = mk(5, 1, 2, 3, CONS, CONS, 1'b0, 2'd0, 16'd2, 2, {2'b00, 1'b1, 1'b0, 30'd1, 30'd1});

        @(negedge clk);
        reset_dut();
        check_reset_outputs("reset");

        for (int v = 0; v < 7; v++) begin
            nm = $sformatf("vec%0d", v);
            mem_lat = 1;
            reset_dut();
            pulse_start();
            for (int t = 0; t < vecs[v].n; t++) begin
                send_tok(vecs[v].tok[t], t == vecs[v].n - 1);
            end
            wait_finished(nm);
            check({nm, "_error"}, 64'(error), 64'(vecs[v].exp_err));
            check({nm, "_error_code"}, 64'(error_code), 64'(vecs[v].exp_code));
            if (!vecs[v].exp_err) check({nm, "_root_addr"}, 64'(root_addr), 64'(vecs[v].exp_root));
            check({nm, "_exec_count"}, 64'(exec_count), 64'(vecs[v].exp_execs));
            if (vecs[v].exp_execs > 0 && wr_q.size() > 0)
                check({nm, "_write_data"}, wr_q[wr_q.size()-1], vecs[v].exp_word);
`ifdef NOUN_LOADER_CELL_COUNT_EN
            check({nm, "_cell_count"}, 64'(cell_count), 64'(vecs[v].exp_execs));
`endif
            @(negedge clk);
            check({nm, "_tok_ready_after"}, 64'(tok_ready), 64'd0);
            check({nm, "_mux_after"}, 64'(mux_controller), 64'd0);
        end

        // 17 atoms into a 16-deep stack.
        mem_lat = 1;
        reset_dut();
        pulse_start();
        for (int i = 0; i < 17; i++) send_tok(i + 1, 1'b0);
        check("ovf_error", 64'(error), 64'd1);
        check("ovf_error_code", 64'(error_code), 64'd2);
        seen_ready = 1'b0;
        tok_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            seen_ready |= tok_ready;
            @(negedge clk);
        end
        tok_valid = 1'b0;
        check("ovf_no_tok_ready", 64'(seen_ready), 64'd0);

        // Re-arm from ERROR without reset; memory model keeps counting from 1.
        pulse_start();
        check("rearm_error_cleared", 64'(error), 64'd0);
        send_tok(5, 1'b0);
        send_tok(7, 1'b0);
        send_tok(CONS, 1'b1);
        wait_finished("rearm");
        check("rearm_error", 64'(error), 64'd0);
        check("rearm_root", 64'(root_addr), 64'd1);

        // Slow memory: ten busy cycles after the request.
        mem_lat = 10;
        reset_dut();
        pulse_start();
        send_tok(5, 1'b0);
        send_tok(7, 1'b0);
        send_tok(CONS, 1'b1);
        seen_ready = 1'b0;
        for (int i = 0; i < 60 && !finished; i++) begin
            seen_ready |= tok_ready;
            @(negedge clk);
        end
        check("slow_finished", 64'(finished), 64'd1);
        check("slow_tok_ready_low", 64'(seen_ready), 64'd0);
        check("slow_exec_count", 64'(exec_count), 64'd1);
        check("slow_root", 64'(root_addr), 64'd1);
        check("slow_error", 64'(error), 64'd0);

        // Reset in the middle of the alloc wait.
        reset_dut();
        pulse_start();
        send_tok(5, 1'b0);
        send_tok(7, 1'b0);
        send_tok(CONS, 1'b1);
        repeat (4) @(negedge clk);
        check("midrst_busy_mux", 64'(mux_controller), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
